// File: rtl/bicubic_sched_pkg.sv
// Shared constants and state encoding for the bicubic tile scheduler and the
// value buffer that sizes its thresholds from the same source dimensions.
package bicubic_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_SRC_W        = 320;
  localparam int DEF_SRC_H        = 240;
  localparam int DEF_XW           = 10;
  localparam int DEF_YW           = 10;
  localparam int DEF_MAX_INFLIGHT = 4;
  localparam int DEF_CW           = 3;

endpackage

// File: rtl/bicubic_tile_scheduler_if.sv
// Tile request channel from the scheduler to the interpolation core
// (valid/ready handshake carrying the source pixel coordinate).
interface bicubic_tile_scheduler_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic          req_last;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/bicubic_credit_counter.sv
// Tracks requests accepted but not yet returned as tiles; saturates at the
// credit limit and flags a return that arrives with nothing outstanding.
module bicubic_credit_counter
  import bicubic_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int CW           = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          underflow_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d     = count_q;
    underflow_o = 1'b0;
    if (dec_i && (count_q == '0)) begin
      underflow_o = 1'b1;
    end
    if (inc_i && !dec_i) begin
      count_d = (count_q >= MAX_C) ? MAX_C : count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/bicubic_tile_scheduler.sv
// Frame-level sequencer: walks source pixels in raster order, issuing one
// 4x4 tile request per pixel under buffer back-pressure and a credit limit.
module bicubic_tile_scheduler
  import bicubic_sched_pkg::*;
#(
  parameter int SRC_W        = DEF_SRC_W,
  parameter int SRC_H        = DEF_SRC_H,
  parameter int XW           = DEF_XW,
  parameter int YW           = DEF_YW,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int CW           = DEF_CW
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_load_ready,
  bicubic_tile_scheduler_if.master req_if,
  input  logic                     i_tile_valid,
  input  logic                     i_eof,
  output logic [15:0]              o_frame_cnt,
  output logic                     o_err
);

  localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_INFLIGHT);

  sched_state_e  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          all_issued_q, all_issued_d;
  logic          eof_seen_q, eof_seen_d;
  logic          valid_q, valid_d;
  logic [XW-1:0] req_x_q, req_x_d;
  logic [YW-1:0] req_y_q, req_y_d;
  logic          last_q, last_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          err_q, err_d;

  logic          hs;
  logic          new_req;
  logic          at_last_pixel;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic          underflow;

  assign hs            = valid_q && req_if.req_ready;
  assign at_last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

  bicubic_credit_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CW          (CW)
  ) u_credit (
    .clk_i       (i_clk),
    .rstn_i      (i_rstn),
    .inc_i       (hs),
    .dec_i       (i_tile_valid),
    .count_o     (inflight),
    .count_next_o(inflight_next),
    .underflow_o (underflow)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_ISSUE;
      ST_ISSUE: if (hs && last_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && eof_seen_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    o_done = (state_q == ST_DONE);
  end

  // A new request is loaded only once the state has been ISSUE for a full
  // cycle, so the first valid follows the start pulse by two edges.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    all_issued_d = all_issued_q;
    eof_seen_d   = eof_seen_q;
    valid_d      = valid_q;
    req_x_d      = req_x_q;
    req_y_d      = req_y_q;
    last_d       = last_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q | underflow | ((state_q == ST_ISSUE) && i_eof);
    new_req      = (state_q == ST_ISSUE) && (state_d == ST_ISSUE) &&
                   (!valid_q || hs) && !all_issued_q && i_load_ready &&
                   (inflight_next < MAX_C);

    if ((state_q == ST_IDLE) && i_start) begin
      x_d          = '0;
      y_d          = '0;
      all_issued_d = 1'b0;
      eof_seen_d   = 1'b0;
      last_d       = 1'b0;
    end
    if ((state_q == ST_DRAIN) && i_eof) begin
      eof_seen_d = 1'b1;
    end
    if (hs) begin
      valid_d = 1'b0;
    end
    if (new_req) begin
      valid_d      = 1'b1;
      req_x_d      = x_q;
      req_y_d      = y_q;
      last_d       = at_last_pixel;
      all_issued_d = at_last_pixel;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      x_q          <= '0;
      y_q          <= '0;
      all_issued_q <= 1'b0;
      eof_seen_q   <= 1'b0;
      valid_q      <= 1'b0;
      req_x_q      <= '0;
      req_y_q      <= '0;
      last_q       <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      all_issued_q <= all_issued_d;
      eof_seen_q   <= eof_seen_d;
      valid_q      <= valid_d;
      req_x_q      <= req_x_d;
      req_y_q      <= req_y_d;
      last_q       <= last_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign req_if.req_valid = valid_q;
  assign req_if.req_x     = req_x_q;
  assign req_if.req_y     = req_y_q;
  assign req_if.req_last  = last_q;
  assign o_frame_cnt      = frame_cnt_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_bicubic_tile_scheduler.sv
// Directed bench for the tile scheduler on a 4x2 source with 4 credits.
module tb_bicubic_tile_scheduler;

  localparam int SRC_W        = 4;
  localparam int SRC_H        = 2;
  localparam int XW           = 10;
  localparam int YW           = 10;
  localparam int MAX_INFLIGHT = 4;
  localparam int CW           = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        load_ready;
  logic        tv_man;
  logic        auto_ret;
  logic        eof;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] frame_cnt;
  logic [2:0]  ret_pipe;
  logic        tile_valid;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          acc;

  always #5 clk = ~clk;

  bicubic_tile_scheduler_if #(.XW(XW), .YW(YW)) req_if ();

  bicubic_tile_scheduler #(
    .SRC_W       (SRC_W),
    .SRC_H       (SRC_H),
    .XW          (XW),
    .YW          (YW),
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CW          (CW)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .i_load_ready(load_ready),
    .req_if      (req_if),
    .i_tile_valid(tile_valid),
    .i_eof       (eof),
    .o_frame_cnt (frame_cnt),
    .o_err       (err)
  );

  // Automatic tile return three edges after each accepted request.
  always @(posedge clk) begin
    if (!auto_ret) ret_pipe <= '0;
    else           ret_pipe <= {ret_pipe[1:0], req_if.req_valid && req_if.req_ready};
  end
  assign tile_valid = auto_ret ? ret_pipe[2] : tv_man;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, req_if.req_valid, 0);
    chk({tag, "_x"},     req_if.req_x, 0);
    chk({tag, "_y"},     req_if.req_y, 0);
    chk({tag, "_last"},  req_if.req_last, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_frame"}, frame_cnt, 0);
    chk({tag, "_err"},   err, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; load_ready = 1'b1; tv_man = 1'b0;
    auto_ret = 1'b0; eof = 1'b0; req_if.req_ready = 1'b1;
    step(); step();
    chk_reset_outputs("rst");
    rstn = 1'b1;
    step();
    chk("idle_valid", req_if.req_valid, 0);
    chk("idle_busy", busy, 0);

    // Full frame, back-to-back requests, tiles returned after 3 cycles
    auto_ret = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_valid", req_if.req_valid, 1);
      chk("t1_x", req_if.req_x, k % 4);
      chk("t1_y", req_if.req_y, k / 4);
      chk("t1_last", req_if.req_last, (k == 7));
      $display("[TB] req x=%0d y=%0d last=%0d", req_if.req_x, req_if.req_y, req_if.req_last);
    end
    step();
    chk("t1_drain_valid", req_if.req_valid, 0);
    chk("t1_drain_busy", busy, 1);
    step(); step(); step();
    auto_ret = 1'b0;
    eof = 1'b1; step(); eof = 1'b0;
    chk("t1_done_early", done, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_done_busy", busy, 0);
    chk("t1_frame", frame_cnt, 1);
    step();
    chk("t1_done_pulse", done, 0);

    // Credit limit: no returns -> exactly 4 accepts
    start = 1'b1; step(); start = 1'b0;
    step();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_if.req_valid && req_if.req_ready) acc++;
      step();
    end
    chk("t2_accepts", acc, 4);
    chk("t2_stalled", req_if.req_valid, 0);
    chk("t2_x", req_if.req_x, 3);
    tv_man = 1'b1; step(); tv_man = 1'b0;
    chk("t2_reenable", req_if.req_valid, 1);
    chk("t2_re_x", req_if.req_x, 0);
    chk("t2_re_y", req_if.req_y, 1);
    step();
    chk("t2_one_more", req_if.req_valid, 0);
    step(); step();
    chk("t2_still_off", req_if.req_valid, 0);

    // Hold under back-pressure while load_ready drops
    req_if.req_ready = 1'b0;
    tv_man = 1'b1; step(); tv_man = 1'b0;
    chk("t3_valid", req_if.req_valid, 1);
    chk("t3_x", req_if.req_x, 1);
    load_ready = 1'b0;
    step();
    chk("t3_hold_valid", req_if.req_valid, 1);
    chk("t3_hold_x", req_if.req_x, 1);
    chk("t3_hold_y", req_if.req_y, 1);
    step();
    chk("t3_hold2_valid", req_if.req_valid, 1);
    req_if.req_ready = 1'b1;
    step();
    chk("t3_accepted", req_if.req_valid, 0);
    tv_man = 1'b1; step(); tv_man = 1'b0;
    chk("t3_noload", req_if.req_valid, 0);
    step();
    chk("t3_noload2", req_if.req_valid, 0);
    load_ready = 1'b1;
    step();
    chk("t3_load_valid", req_if.req_valid, 1);
    chk("t3_load_x", req_if.req_x, 2);
    chk("t3_load_y", req_if.req_y, 1);
    chk("t3_load_last", req_if.req_last, 0);
    step();
    chk("t3_credit_off", req_if.req_valid, 0);
    tv_man = 1'b1; step();
    chk("t3_last_valid", req_if.req_valid, 1);
    chk("t3_last_x", req_if.req_x, 3);
    chk("t3_last_flag", req_if.req_last, 1);
    step(); tv_man = 1'b0;
    chk("t3_drain_valid", req_if.req_valid, 0);
    chk("t3_drain_busy", busy, 1);

    // eof before the final tile returns
    eof = 1'b1; step(); eof = 1'b0;
    chk("t4_eof_done", done, 0);
    tv_man = 1'b1; step(); step();
    chk("t4_two_left", done, 0);
    step(); tv_man = 1'b0;
    chk("t4_zero_cond", done, 0);
    chk("t4_zero_busy", busy, 1);
    step();
    chk("t4_done", done, 1);
    chk("t4_done_busy", busy, 0);
    chk("t4_frame", frame_cnt, 2);
    chk("t4_no_err", err, 0);
    step();
    chk("t4_done_pulse", done, 0);

    // Underflow error, then start ignored during ISSUE
    tv_man = 1'b1; step(); tv_man = 1'b0;
    chk("t5_err", err, 1);
    step();
    chk("t5_err_sticky", err, 1);
    req_if.req_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t5_first_x", req_if.req_x, 0);
    req_if.req_ready = 1'b1; step(); req_if.req_ready = 1'b0;
    chk("t5_second_x", req_if.req_x, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("t5_ign_x", req_if.req_x, 1);
    chk("t5_ign_y", req_if.req_y, 0);
    chk("t5_ign_valid", req_if.req_valid, 1);
    chk("t5_ign_busy", busy, 1);
    req_if.req_ready = 1'b1; step(); req_if.req_ready = 1'b0;
    chk("t5_next_x", req_if.req_x, 2);

    // Reset mid-ISSUE, fresh restart with a full credit window
    rstn = 1'b0; step(); rstn = 1'b1;
    chk_reset_outputs("t6_rst");
    step();
    chk("t6_idle_valid", req_if.req_valid, 0);
    chk("t6_idle_busy", busy, 0);
    req_if.req_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t6_valid", req_if.req_valid, 1);
    chk("t6_x", req_if.req_x, 0);
    chk("t6_y", req_if.req_y, 0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_if.req_valid && req_if.req_ready) acc++;
      step();
    end
    chk("t6_accepts", acc, 4);
    eof = 1'b1; step(); eof = 1'b0;
    chk("t6_eof_issue_err", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
